// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM stage: req/ready handshake to a
// variable-latency memory, pipeline stall, load-data capture and timeout fault.
module dmem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_exmem,
    input  logic              mem_write_exmem,
    input  logic [DATA_W-1:0] alu_result_exmem,
    input  logic [DATA_W-1:0] write_data_exmem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] memdata,
    output logic              mem_stall,
    output logic              mem_fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] memdata_q, memdata_d;
    logic              fault_q, fault_d;
    logic              access;

    assign access = mem_read_exmem | mem_write_exmem;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {DATA_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            memdata_q <= {DATA_W{1'b0}};
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            memdata_q <= memdata_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        memdata_d = memdata_q;
        fault_d   = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // A store wins when both read and write are flagged
                    addr_d  = alu_result_exmem;
                    wdata_d = write_data_exmem;
                    we_d    = mem_write_exmem;
                    req_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        memdata_d = dmem_rdata;
                    end else begin
                        memdata_d = memdata_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the request; a timed-out load returns zero
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        memdata_d = {DATA_W{1'b0}};
                    end else begin
                        memdata_d = memdata_q;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign mem_stall  = ((state_q == ST_IDLE) && access) || (state_q == ST_WAIT);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign memdata    = memdata_q;
    assign mem_fault  = fault_q;

endmodule
